// File: rtl/alu_pkg.sv
// Shared types for the ALU and its two-port sharing controller.
package alu_pkg;

   localparam int ALU_OPC_W = 5;

   // ALU opcodes; values not listed here fall through to the add path.
   typedef enum logic [ALU_OPC_W-1:0] {
      ALU_ADD = 5'h00,
      ALU_SUB = 5'h02,
      ALU_AND = 5'h05,
      ALU_OR  = 5'h06,
      ALU_XOR = 5'h07,
      ALU_SLL = 5'h08,
      ALU_SRL = 5'h09,
      ALU_SRA = 5'h0A
   } alu_op_e;

   // Controller sequencing: accept, compute, hand back the result.
   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   // Status flags, packed so the vector form reads {z,v,n}.
   typedef struct packed {
      logic z;
      logic v;
      logic n;
   } flags_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. z reflects every result; v and n describe signed
// arithmetic and are only raised for ADD/SUB, so logic and shift ops
// report v=0, n=0 regardless of the result's top bit.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPC_W = 5
) (
   input  logic [OPC_W-1:0] opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags
);

   localparam int SH_W = $clog2(WIDTH);
   localparam int MSB  = WIDTH - 1;

   logic [ALU_OPC_W-1:0] op;
   logic [SH_W-1:0]      shamt;
   logic                 arith;
   logic                 sub;
   logic                 ovf;
   flags_t               flags_s;

   assign op    = ALU_OPC_W'(opcode);
   assign shamt = b[SH_W-1:0];

   // Operation select; anything unrecognised takes the add path.
   always_comb begin
      // NOTE: every output of this block gets a default before the case so no path can leave it unassigned and infer a latch.
      result = a + b;
      arith  = 1'b1;
      sub    = 1'b0;
      case (op)
         ALU_ADD: ;
         ALU_SUB: begin result = a - b;                          sub   = 1'b1; end
         ALU_AND: begin result = a & b;                          arith = 1'b0; end
         ALU_OR:  begin result = a | b;                          arith = 1'b0; end
         ALU_XOR: begin result = a ^ b;                          arith = 1'b0; end
         ALU_SLL: begin result = a << shamt;                     arith = 1'b0; end
         ALU_SRL: begin result = a >> shamt;                     arith = 1'b0; end
         ALU_SRA: begin result = $unsigned($signed(a) >>> shamt); arith = 1'b0; end
         default: ;
      endcase
   end

   // Signed overflow: operands agree (add) or differ (sub) in sign and the result sign flips.
   assign ovf = arith & ((sub ? (a[MSB] != b[MSB]) : (a[MSB] == b[MSB])) & (result[MSB] != a[MSB]));

   assign flags_s.z = (result == '0);
   assign flags_s.v = ovf;
   assign flags_s.n = arith & result[MSB];
   assign flags     = flags_s;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two valid/ready requesters with round-robin
// arbitration. Operands are registered before the ALU and result/flags
// after it; only one operation is in flight at a time.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int OPC_W       = 5,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPC_W-1:0] req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic [2:0]       rsp0_flags,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPC_W-1:0] req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic [2:0]       rsp1_flags,
   output logic             busy
);

   localparam int              CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;   // 1 = port 1 served last, so port 0 wins the next tie
   logic             id;           // port that owns the in-flight op
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             capture;
   logic             rsp_done;
   logic [OPC_W-1:0] op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   flags_t           flags_q;
   logic [WIDTH-1:0] alu_res;
   logic [2:0]       alu_flags;

   // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign accept     = req0_ready | req1_ready;
   assign capture    = (state == EXEC) && (cnt == '0);
   assign rsp_done   = (state == RESP) && (id ? rsp1_ready : rsp0_ready);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values, independent of block ordering.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)      state_nxt = EXEC;
         EXEC:    if (cnt == '0)   state_nxt = RESP;
         RESP:    if (rsp_done)    state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Operand latch and EXEC countdown; the ALU only ever sees these registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         id   <= 1'b0;
         cnt  <= '0;
      end else if (accept) begin
         op_q <= req1_ready ? req1_opcode : req0_opcode;
         a_q  <= req1_ready ? req1_a      : req0_a;
         b_q  <= req1_ready ? req1_b      : req0_b;
         id   <= req1_ready;
         cnt  <= CNT_LOAD;
      end else if ((state == EXEC) && (cnt != '0)) begin
         cnt  <= cnt - 1'b1;
      end
   end

   // Result/flag capture at the end of EXEC; held stable through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         flags_q <= '0;
      end else if (capture) begin
         res_q   <= alu_res;
         flags_q <= alu_flags;
      end
   end

   // Fairness history, updated when a response is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        last_grant <= 1'b1;
      else if (rsp_done) last_grant <= id;
   end

   alu #(
      .WIDTH (WIDTH),
      .OPC_W (OPC_W)
   ) u_alu (
      .opcode (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res),
      .flags  (alu_flags)
   );

   assign rsp0_valid  = (state == RESP) & ~id;
   assign rsp1_valid  = (state == RESP) &  id;
   assign rsp0_result = res_q;
   assign rsp1_result = res_q;
   assign rsp0_flags  = flags_q;
   assign rsp1_flags  = flags_q;
   assign busy        = (state != IDLE);

   // A requester must keep valid high until it is accepted.
   a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req0_valid && !req0_ready) |=> req0_valid);
   a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req1_valid && !req1_ready) |=> req1_valid);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a vector table of single operations
// plus hand-written sequences for ties, backpressure, reset and a
// three-cycle EXEC build.
module tb_alu_share_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [4:0]  req0_opcode;
   logic [31:0] req0_a, req0_b, rsp0_result;
   logic [2:0]  rsp0_flags;
   logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [4:0]  req1_opcode;
   logic [31:0] req1_a, req1_b, rsp1_result;
   logic [2:0]  rsp1_flags;
   logic        busy;

   logic        d3_req0_valid, d3_req0_ready, d3_rsp0_valid, d3_rsp0_ready;
   logic [4:0]  d3_req0_opcode;
   logic [31:0] d3_req0_a, d3_req0_b, d3_rsp0_result;
   logic [2:0]  d3_rsp0_flags;
   logic        d3_req1_valid, d3_req1_ready, d3_rsp1_valid, d3_rsp1_ready;
   logic [4:0]  d3_req1_opcode;
   logic [31:0] d3_req1_a, d3_req1_b, d3_rsp1_result;
   logic [2:0]  d3_rsp1_flags;
   logic        d3_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.WIDTH(32), .OPC_W(5), .EXEC_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_flags(rsp1_flags),
      .busy(busy)
   );

   alu_share_ctrl #(.WIDTH(32), .OPC_W(5), .EXEC_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_opcode(d3_req0_opcode),
      .req0_a(d3_req0_a), .req0_b(d3_req0_b),
      .rsp0_valid(d3_rsp0_valid), .rsp0_ready(d3_rsp0_ready), .rsp0_result(d3_rsp0_result),
      .rsp0_flags(d3_rsp0_flags),
      .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_opcode(d3_req1_opcode),
      .req1_a(d3_req1_a), .req1_b(d3_req1_b),
      .rsp1_valid(d3_rsp1_valid), .rsp1_ready(d3_rsp1_ready), .rsp1_result(d3_rsp1_result),
      .rsp1_flags(d3_rsp1_flags),
      .busy(d3_busy)
   );

   typedef struct {
      string       name;
      int          port;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flags;   // {z,v,n}
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic get_ready(input int p);
      return (p == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic get_rsp_valid(input int p);
      return (p == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   function automatic logic [31:0] get_result(input int p);
      return (p == 0) ? rsp0_result : rsp1_result;
   endfunction

   function automatic logic [2:0] get_flags(input int p);
      return (p == 0) ? rsp0_flags : rsp1_flags;
   endfunction

   task automatic drive_req(input int p, input logic v, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic set_rsp_ready(input int p, input logic v);
      if (p == 0) rsp0_ready = v;
      else        rsp1_ready = v;
   endtask

   // Called just after a rising edge; returns the number of extra cycles waited.
   task automatic wait_ready(input int p, input string name, output int waited);
      waited = 0;
      @(negedge clk);
      while (!get_ready(p) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_ready"}, {31'b0, get_ready(p)}, 32'd1);
   endtask

   // Called just after the accept edge; ends on a falling edge with the response showing.
   task automatic wait_rsp(input int p, input logic [31:0] exp_res, input logic [2:0] exp_flags,
                           input int exp_lat, input string name);
      int lat = 0;
      @(negedge clk);
      while (!get_rsp_valid(p) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_rsp_valid"}, {31'b0, get_rsp_valid(p)}, 32'd1);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_other_rsp_valid"}, {31'b0, get_rsp_valid(1 - p)}, 32'd0);
      check({name, "_result"}, get_result(p), exp_res);
      check({name, "_flags"}, {29'b0, get_flags(p)}, {29'b0, exp_flags});
   endtask

   task automatic finish_rsp(input int p);
      set_rsp_ready(p, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(p, 1'b0);
   endtask

   // One complete operation on an idle controller; starts and ends just after a rising edge.
   task automatic run_op(input vec_t v);
      int waited;
      drive_req(v.port, 1'b1, v.op, v.a, v.b);
      wait_ready(v.port, v.name, waited);
      check({v.name, "_ready_same_cycle"}, waited, 0);
      @(posedge clk); #1;
      drive_req(v.port, 1'b0, 5'h0, 32'h0, 32'h0);
      wait_rsp(v.port, v.res, v.flags, 1, v.name);
      finish_rsp(v.port);
      @(negedge clk);
      check({v.name, "_idle_after"}, {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"},        {31'b0, busy},       32'd0);
      check({name, "_rsp0_valid"},  {31'b0, rsp0_valid}, 32'd0);
      check({name, "_rsp1_valid"},  {31'b0, rsp1_valid}, 32'd0);
      check({name, "_req0_ready"},  {31'b0, req0_ready}, 32'd0);
      check({name, "_req1_ready"},  {31'b0, req1_ready}, 32'd0);
      check({name, "_rsp0_result"}, rsp0_result,         32'd0);
      check({name, "_rsp1_result"}, rsp1_result,         32'd0);
      check({name, "_rsp0_flags"},  {29'b0, rsp0_flags}, 32'd0);
      check({name, "_rsp1_flags"},  {29'b0, rsp1_flags}, 32'd0);
   endtask

   // Asserts reset now, idles every requester, releases on a falling edge two cycles later.
   task automatic apply_reset();
      rst_n = 1'b0;
      drive_req(0, 1'b0, 5'h0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 5'h0, 32'h0, 32'h0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;
      int exp_port;
      int lat;
      logic [31:0] next_a [2];
      logic [31:0] fixed_b [2];
      logic [31:0] exp_res;
      logic [31:0] held_res;

      vecs[0]  = '{"xor",      0, ALU_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 3'b000};
      vecs[1]  = '{"and_zero", 0, ALU_AND, 32'h000000F0, 32'h0000000F, 32'h00000000, 3'b100};
      vecs[2]  = '{"sll31",    1, ALU_SLL, 32'h00000001, 32'd31,       32'h80000000, 3'b000};
      vecs[3]  = '{"srl4",     1, ALU_SRL, 32'h80000000, 32'd4,        32'h08000000, 3'b000};
      vecs[4]  = '{"sra4",     1, ALU_SRA, 32'h80000000, 32'd4,        32'hF8000000, 3'b000};
      vecs[5]  = '{"add_ovf",  0, ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b011};
      vecs[6]  = '{"add_wrap", 0, ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100};
      vecs[7]  = '{"sub_zero", 0, ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 3'b100};
      vecs[8]  = '{"sub_neg",  1, ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3'b001};
      vecs[9]  = '{"sub_ovf",  1, ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b010};
      vecs[10] = '{"or",       0, ALU_OR,  32'h000000F0, 32'h0000000F, 32'h000000FF, 3'b000};
      vecs[11] = '{"undef_op", 1, 5'h1F,   32'h00000002, 32'h00000003, 32'h00000005, 3'b000};

      d3_req0_valid = 1'b0; d3_req0_opcode = 5'h0; d3_req0_a = '0; d3_req0_b = '0; d3_rsp0_ready = 1'b0;
      d3_req1_valid = 1'b0; d3_req1_opcode = 5'h0; d3_req1_a = '0; d3_req1_b = '0; d3_rsp1_ready = 1'b0;

      // Reset state.
      rst_n = 1'b0;
      drive_req(0, 1'b0, 5'h0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 5'h0, 32'h0, 32'h0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single operations from the table.
      for (int i = 0; i < 12; i++) run_op(vecs[i]);

      // Continuous ties starting from reset: grants alternate 0,1,0,1...
      @(negedge clk);
      apply_reset();
      @(posedge clk); #1;
      next_a[0] = 32'd1;   fixed_b[0] = 32'h10;
      next_a[1] = 32'd100; fixed_b[1] = 32'h20;
      drive_req(0, 1'b1, ALU_ADD, next_a[0], fixed_b[0]);
      drive_req(1, 1'b1, ALU_ADD, next_a[1], fixed_b[1]);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      exp_port = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("tie%0d_grant", i), {31'b0, get_ready(exp_port)}, 32'd1);
         check($sformatf("tie%0d_other", i), {31'b0, get_ready(1 - exp_port)}, 32'd0);
         @(posedge clk); #1;
         exp_res = next_a[exp_port] + fixed_b[exp_port];
         next_a[exp_port] = next_a[exp_port] + 32'd1;
         drive_req(exp_port, 1'b1, ALU_ADD, next_a[exp_port], fixed_b[exp_port]);
         wait_rsp(exp_port, exp_res, 3'b000, 1, $sformatf("tie%0d", i));
         @(posedge clk); #1;
         exp_port = 1 - exp_port;
      end

      // Backpressure on port 1 while port 0 waits.
      @(negedge clk);
      apply_reset();
      @(posedge clk); #1;
      drive_req(1, 1'b1, ALU_ADD, 32'h100, 32'h23);
      wait_ready(1, "bp_p1", waited);
      @(posedge clk); #1;
      drive_req(1, 1'b0, 5'h0, 32'h0, 32'h0);
      drive_req(0, 1'b1, ALU_OR, 32'hF0, 32'h0F);
      wait_rsp(1, 32'h123, 3'b000, 1, "bp_p1");
      held_res = 32'h123;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("bp%0d_rsp1_valid", i), {31'b0, rsp1_valid}, 32'd1);
         check($sformatf("bp%0d_result", i), rsp1_result, held_res);
         check($sformatf("bp%0d_req0_ready", i), {31'b0, req0_ready}, 32'd0);
         check($sformatf("bp%0d_busy", i), {31'b0, busy}, 32'd1);
      end
      finish_rsp(1);
      @(negedge clk);
      check("bp_release_busy", {31'b0, busy}, 32'd0);
      check("bp_release_req0_ready", {31'b0, req0_ready}, 32'd1);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 5'h0, 32'h0, 32'h0);
      wait_rsp(0, 32'hFF, 3'b000, 1, "bp_p0");
      finish_rsp(0);

      // Reset while in EXEC.
      drive_req(0, 1'b1, ALU_ADD, 32'h11, 32'h22);
      wait_ready(0, "rst_exec", waited);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 5'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("rst_exec_busy_before", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_exec");
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rst_exec_quiet%0d", i), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      @(posedge clk); #1;
      run_op(vecs[0]);

      // Reset while in RESP with the response pending.
      drive_req(1, 1'b1, ALU_SUB, 32'h50, 32'h10);
      wait_ready(1, "rst_resp", waited);
      @(posedge clk); #1;
      drive_req(1, 1'b0, 5'h0, 32'h0, 32'h0);
      wait_rsp(1, 32'h40, 3'b000, 1, "rst_resp");
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_resp");
      @(negedge clk);
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rst_resp_quiet%0d", i), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      @(posedge clk); #1;
      run_op(vecs[2]);

      // Three-cycle EXEC build: accept edge k -> response after edge k+3.
      d3_req0_valid = 1'b1; d3_req0_opcode = ALU_ADD; d3_req0_a = 32'd3; d3_req0_b = 32'd4;
      @(negedge clk);
      check("d3_ready", {31'b0, d3_req0_ready}, 32'd1);
      @(posedge clk); #1;
      d3_req0_valid = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!d3_rsp0_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("d3_latency", lat, 3);
      check("d3_result", d3_rsp0_result, 32'd7);
      d3_rsp0_ready = 1'b1;
      @(posedge clk); #1;
      d3_rsp0_ready = 1'b0;
      @(negedge clk);
      check("d3_idle_after", {31'b0, d3_busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
